// File: rtl/rr_sel_encoder_2b.sv
// Round-robin 4-way sequencer producing the registered 2-bit select code for a 2-to-4 decoder,
// with grant hold/timeout and break-before-make dead time between grants.
module rr_sel_encoder_2b #(
   parameter int HOLD_MAX   = 15,
   parameter int GAP_CYCLES = 1,
   parameter int CNT_W      = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       done,
   output logic [1:0] sel_code,
   output logic       sel_valid,
   output logic [3:0] grant_onehot,
   output logic       timeout
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       sel_code_q, sel_code_d;
   logic             sel_valid_q, sel_valid_d;
   logic [3:0]       grant_onehot_q, grant_onehot_d;
   logic             timeout_q, timeout_d;

   logic [1:0]       win;
   logic             found;
   logic [1:0]       idx;
   logic [CNT_W-1:0] cnt_inc;

   // Search starts just after the last winner, so the last winner has lowest priority.
   always_comb begin
      win   = 2'd0;
      found = 1'b0;
      idx   = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         idx = ptr_q + 2'(i);
         if (req[idx] && !found) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      state_d        = state_q;
      ptr_d          = ptr_q;
      cnt_d          = cnt_q;
      sel_code_d     = sel_code_q;
      sel_valid_d    = sel_valid_q;
      grant_onehot_d = grant_onehot_q;
      timeout_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d        = S_GRANT;
               sel_code_d     = win;
               sel_valid_d    = 1'b1;
               grant_onehot_d = 4'b0001 << win;
               ptr_d          = win;
               cnt_d          = '0;
            end
         end
         S_GRANT: begin
            cnt_d = cnt_inc;
            // done has priority over the hold limit; sel_code is left untouched for the decoder.
            if (done || (cnt_q == HOLD_LAST)) begin
               state_d        = S_GAP;
               sel_valid_d    = 1'b0;
               grant_onehot_d = 4'b0000;
               cnt_d          = '0;
               timeout_d      = !done;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d        = S_IDLE;
            sel_valid_d    = 1'b0;
            grant_onehot_d = 4'b0000;
            cnt_d          = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         ptr_q          <= 2'd3;
         cnt_q          <= '0;
         sel_code_q     <= 2'd0;
         sel_valid_q    <= 1'b0;
         grant_onehot_q <= 4'b0000;
         timeout_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         ptr_q          <= ptr_d;
         cnt_q          <= cnt_d;
         sel_code_q     <= sel_code_d;
         sel_valid_q    <= sel_valid_d;
         grant_onehot_q <= grant_onehot_d;
         timeout_q      <= timeout_d;
      end
   end

   assign sel_code     = sel_code_q;
   assign sel_valid    = sel_valid_q;
   assign grant_onehot = grant_onehot_q;
   assign timeout      = timeout_q;

endmodule

// File: tb/tb_rr_sel_encoder_2b.sv
// Bench for rr_sel_encoder_2b: cycle vectors with expected outputs pushed to a queue on drive
// and popped when the registered outputs are sampled after the clock edge.
module tb_rr_sel_encoder_2b;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic       done;
   logic [1:0] sel_code;
   logic       sel_valid;
   logic [3:0] grant_onehot;
   logic       timeout;

   always #5 clk = ~clk;

   rr_sel_encoder_2b #(
      .HOLD_MAX  (15),
      .GAP_CYCLES(1),
      .CNT_W     (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .done        (done),
      .sel_code    (sel_code),
      .sel_valid   (sel_valid),
      .grant_onehot(grant_onehot),
      .timeout     (timeout)
   );

   typedef struct {
      logic       rst_n;
      logic [3:0] req;
      logic       done;
      logic [7:0] exp;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] exp_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   logic [1:0] prev_code = 2'd0;
   logic       prev_ok   = 1'b0;

   // Output record: {sel_code, sel_valid, grant_onehot, timeout}.
   function automatic logic [7:0] e(input logic [1:0] code, input logic v,
                                    input logic [3:0] oh, input logic to);
      return {code, v, oh, to};
   endfunction

   task automatic add(input logic r, input logic [3:0] rq, input logic d, input logic [7:0] ex);
      vec_t t;
      t.rst_n = r;
      t.req   = rq;
      t.done  = d;
      t.exp   = ex;
      vecs.push_back(t);
   endtask

   task automatic compare(input string name);
      logic [7:0] act;
      logic [7:0] ex;
      act = {sel_code, sel_valid, grant_onehot, timeout};
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: scoreboard empty, got %b", name, act);
      end else begin
         ex = exp_q.pop_front();
         if (act !== ex) begin
            n_fail++;
            $display("FAIL %s: got code/valid/onehot/timeout %b, expected %b", name, act, ex);
         end
      end
   endtask

   task automatic check_inv(input string name);
      n_checks++;
      if (sel_valid ? (grant_onehot !== (4'b0001 << sel_code)) : (grant_onehot !== 4'b0000)) begin
         n_fail++;
         $display("FAIL %s_onehot_inv: valid=%b code=%0d onehot=%b", name, sel_valid, sel_code, grant_onehot);
      end
      if (!sel_valid && prev_ok) begin
         n_checks++;
         if (sel_code !== prev_code) begin
            n_fail++;
            $display("FAIL %s_code_stable: code=%0d, expected held %0d", name, sel_code, prev_code);
         end
      end
      prev_code = sel_code;
      prev_ok   = rst_n;
   endtask

   task automatic step(input logic r, input logic [3:0] rq, input logic d,
                       input logic [7:0] ex, input string name);
      @(negedge clk);
      rst_n = r;
      req   = rq;
      done  = d;
      if (!r) prev_ok = 1'b0;
      exp_q.push_back(ex);
      @(posedge clk);
      #1;
      compare(name);
      check_inv(name);
   endtask

   initial begin
      // Reset, single request, then all requesters with done one cycle into each grant.
      add(1'b0, 4'b0000, 1'b0, e(2'd0, 1'b0, 4'b0000, 1'b0));
      add(1'b1, 4'b0100, 1'b0, e(2'd2, 1'b1, 4'b0100, 1'b0));
      add(1'b1, 4'b0100, 1'b1, e(2'd2, 1'b0, 4'b0000, 1'b0));
      add(1'b1, 4'b0000, 1'b0, e(2'd2, 1'b0, 4'b0000, 1'b0));
      add(1'b1, 4'b0000, 1'b0, e(2'd2, 1'b0, 4'b0000, 1'b0));
      add(1'b0, 4'b1111, 1'b0, e(2'd0, 1'b0, 4'b0000, 1'b0));
      add(1'b1, 4'b1111, 1'b0, e(2'd0, 1'b1, 4'b0001, 1'b0));
      add(1'b1, 4'b1111, 1'b1, e(2'd0, 1'b0, 4'b0000, 1'b0));
      add(1'b1, 4'b1111, 1'b0, e(2'd0, 1'b0, 4'b0000, 1'b0));
      add(1'b1, 4'b1111, 1'b0, e(2'd1, 1'b1, 4'b0010, 1'b0));
      add(1'b1, 4'b1111, 1'b1, e(2'd1, 1'b0, 4'b0000, 1'b0));
      add(1'b1, 4'b1111, 1'b0, e(2'd1, 1'b0, 4'b0000, 1'b0));
      add(1'b1, 4'b1111, 1'b0, e(2'd2, 1'b1, 4'b0100, 1'b0));
      add(1'b1, 4'b1111, 1'b1, e(2'd2, 1'b0, 4'b0000, 1'b0));
      add(1'b1, 4'b1111, 1'b0, e(2'd2, 1'b0, 4'b0000, 1'b0));
      add(1'b1, 4'b1111, 1'b0, e(2'd3, 1'b1, 4'b1000, 1'b0));
      add(1'b1, 4'b1111, 1'b1, e(2'd3, 1'b0, 4'b0000, 1'b0));
      add(1'b1, 4'b1111, 1'b0, e(2'd3, 1'b0, 4'b0000, 1'b0));
      add(1'b1, 4'b1111, 1'b0, e(2'd0, 1'b1, 4'b0001, 1'b0));
      // Dropping the request does not release the grant.
      add(1'b1, 4'b0000, 1'b0, e(2'd0, 1'b1, 4'b0001, 1'b0));
      add(1'b1, 4'b0000, 1'b1, e(2'd0, 1'b0, 4'b0000, 1'b0));
      add(1'b1, 4'b0000, 1'b0, e(2'd0, 1'b0, 4'b0000, 1'b0));

      rst_n = 1'b0;
      req   = 4'b0000;
      done  = 1'b0;
      #1;
      exp_q.push_back(e(2'd0, 1'b0, 4'b0000, 1'b0));
      compare("reset_async");

      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i].rst_n, vecs[i].req, vecs[i].done, vecs[i].exp, $sformatf("vec%0d", i));

      // Hold timeout: 15 granted cycles, one-cycle timeout pulse, gap, regrant.
      step(1'b0, 4'b0000, 1'b0, e(2'd0, 1'b0, 4'b0000, 1'b0), "to_reset");
      for (int i = 0; i < 15; i++)
         step(1'b1, 4'b0001, 1'b0, e(2'd0, 1'b1, 4'b0001, 1'b0), $sformatf("to_hold%0d", i));
      step(1'b1, 4'b0001, 1'b0, e(2'd0, 1'b0, 4'b0000, 1'b1), "to_pulse");
      step(1'b1, 4'b0001, 1'b0, e(2'd0, 1'b0, 4'b0000, 1'b0), "to_idle");
      step(1'b1, 4'b0001, 1'b0, e(2'd0, 1'b1, 4'b0001, 1'b0), "to_regrant");

      // done on the last hold cycle wins over the timeout.
      for (int i = 1; i <= 14; i++)
         step(1'b1, 4'b0001, 1'b0, e(2'd0, 1'b1, 4'b0001, 1'b0), $sformatf("dw_hold%0d", i));
      step(1'b1, 4'b0000, 1'b1, e(2'd0, 1'b0, 4'b0000, 1'b0), "dw_release");
      step(1'b1, 4'b0000, 1'b0, e(2'd0, 1'b0, 4'b0000, 1'b0), "dw_gap_exit");
      step(1'b1, 4'b0000, 1'b0, e(2'd0, 1'b0, 4'b0000, 1'b0), "dw_idle");

      // Asynchronous reset in the middle of a grant to requester 3.
      step(1'b1, 4'b1000, 1'b0, e(2'd3, 1'b1, 4'b1000, 1'b0), "ar_grant3");
      step(1'b1, 4'b1000, 1'b0, e(2'd3, 1'b1, 4'b1000, 1'b0), "ar_hold");
      #2;
      rst_n   = 1'b0;
      prev_ok = 1'b0;
      #1;
      exp_q.push_back(e(2'd0, 1'b0, 4'b0000, 1'b0));
      compare("ar_midcycle");
      step(1'b0, 4'b1000, 1'b0, e(2'd0, 1'b0, 4'b0000, 1'b0), "ar_held");
      step(1'b1, 4'b1000, 1'b0, e(2'd3, 1'b1, 4'b1000, 1'b0), "ar_regrant3");
      step(1'b1, 4'b1000, 1'b1, e(2'd3, 1'b0, 4'b0000, 1'b0), "ar_done");

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
